// File: rtl/nec_pkg.sv
// Shared NEC infrared protocol definitions: state encoding, default tick
// counts on the 56.25 us protocol clock, and small helpers.
`timescale 1ns/1ps
package nec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } nec_state_t;

  localparam int NEC_CLK_PERIOD_NS     = 56250;
  localparam int NEC_WORD_BITS         = 32;
  localparam int NEC_BURST_TICKS       = 10;
  localparam int NEC_LEAD_MARK_TICKS   = 160;
  localparam int NEC_LEAD_SPACE_TICKS  = 80;
  localparam int NEC_ZERO_SPACE_TICKS  = 10;
  localparam int NEC_ONE_SPACE_TICKS   = 30;
  localparam int NEC_GAP_TICKS         = 89;

  // Largest of the six tick counts; sizes the shared down-counter.
  function automatic int maxTicks(input int a, input int b, input int c,
                                  input int d, input int e, input int f);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    if (f > m) m = f;
    return m;
  endfunction

  // States in which the line carries a carrier burst (driven low).
  function automatic logic isMark(input nec_state_t s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

endpackage

// File: rtl/nec_tick_timer.sv
// Loadable down-counter with a zero flag. A load of N-1 makes the flag rise
// exactly N-1 ticks later, so a phase loaded with N-1 lasts N ticks when the
// owner moves on at the tick where the flag is set.
`timescale 1ns/1ps
module nec_tick_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  // Load has priority; otherwise count down and rest at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/ir_transmitter.sv
// NEC infrared transmitter: serialises a 32-bit word MSB first onto an
// active-low IR line as leader mark/space, 32 pulse-distance bits, a stop
// burst and an idle guard gap. The line comes straight from a flop.
`timescale 1ns/1ps
module ir_transmitter
  import nec_pkg::*;
#(
  parameter int BURST_TICKS      = NEC_BURST_TICKS,
  parameter int LEAD_MARK_TICKS  = NEC_LEAD_MARK_TICKS,
  parameter int LEAD_SPACE_TICKS = NEC_LEAD_SPACE_TICKS,
  parameter int ZERO_SPACE_TICKS = NEC_ZERO_SPACE_TICKS,
  parameter int ONE_SPACE_TICKS  = NEC_ONE_SPACE_TICKS,
  parameter int GAP_TICKS        = NEC_GAP_TICKS
) (
  input  logic        nec_clk,
  input  logic        reset,
  input  logic [31:0] tx_word,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        ir_signal,
  output logic        tx_done
);

  localparam int MAX_TICKS = maxTicks(BURST_TICKS, LEAD_MARK_TICKS, LEAD_SPACE_TICKS,
                                      ZERO_SPACE_TICKS, ONE_SPACE_TICKS, GAP_TICKS);
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  nec_state_t  state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [4:0]  bitCnt_q, bitCnt_d;
  logic        ir_q, ir_d;
  logic        done_q, done_d;

  logic             timerLoad;
  logic [CNT_W-1:0] timerValue;
  logic             timerZero;

  nec_tick_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk_i  (nec_clk),
    .rst_i  (reset),
    .load_i (timerLoad),
    .value_i(timerValue),
    .zero_o (timerZero)
  );

  // State, shift register, bit counter and the registered line/done outputs.
  always_ff @(posedge nec_clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitCnt_q <= '0;
      ir_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitCnt_q <= bitCnt_d;
      ir_q     <= ir_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: each phase reloads the timer with its length minus one
  // and advances when the timer reads zero. The line level is taken from the
  // next state so it changes on the same edge as the state.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitCnt_d   = bitCnt_q;
    done_d     = 1'b0;
    timerLoad  = 1'b0;
    timerValue = '0;
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d    = LEAD_MARK;
          shift_d    = tx_word;
          timerLoad  = 1'b1;
          timerValue = CNT_W'(LEAD_MARK_TICKS - 1);
        end
      end
      LEAD_MARK: begin
        if (timerZero) begin
          state_d    = LEAD_SPACE;
          timerLoad  = 1'b1;
          timerValue = CNT_W'(LEAD_SPACE_TICKS - 1);
        end
      end
      LEAD_SPACE: begin
        if (timerZero) begin
          state_d    = BIT_MARK;
          bitCnt_d   = 5'd31;
          timerLoad  = 1'b1;
          timerValue = CNT_W'(BURST_TICKS - 1);
        end
      end
      BIT_MARK: begin
        if (timerZero) begin
          state_d    = BIT_SPACE;
          timerLoad  = 1'b1;
          timerValue = shift_q[31] ? CNT_W'(ONE_SPACE_TICKS - 1)
                                   : CNT_W'(ZERO_SPACE_TICKS - 1);
        end
      end
      BIT_SPACE: begin
        if (timerZero) begin
          shift_d    = {shift_q[30:0], 1'b0};
          timerLoad  = 1'b1;
          timerValue = CNT_W'(BURST_TICKS - 1);
          if (bitCnt_q == 5'd0) begin
            state_d = STOP_MARK;
          end else begin
            state_d  = BIT_MARK;
            bitCnt_d = bitCnt_q - 5'd1;
          end
        end
      end
      STOP_MARK: begin
        if (timerZero) begin
          state_d    = GAP;
          done_d     = 1'b1;
          timerLoad  = 1'b1;
          timerValue = CNT_W'(GAP_TICKS - 1);
        end
      end
      GAP: begin
        if (timerZero) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ir_d = ~isMark(state_d);
  end

  assign tx_ready  = (state_q == IDLE);
  assign ir_signal = ir_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_ir_transmitter.sv
// Bench for ir_transmitter: builds the expected line waveform of each frame
// from the NEC timing rules, decodes the observed line back into a word, and
// checks done/ready timing, back-to-back framing, busy-time input blocking and
// asynchronous reset in the middle of a frame.
`timescale 1ns/1ps
module tb_ir_transmitter;

  localparam int HALF_PERIOD_NS = 28125;
  localparam int T_BURST = 10;
  localparam int T_LEAD_MARK = 160;
  localparam int T_LEAD_SPACE = 80;
  localparam int T_ZERO_SPACE = 10;
  localparam int T_ONE_SPACE = 30;
  localparam int T_GAP = 89;

  logic        nec_clk = 1'b0;
  logic        reset;
  logic [31:0] tx_word;
  logic        tx_valid;
  logic        tx_ready;
  logic        ir_signal;
  logic        tx_done;

  int total = 0;
  int bad = 0;
  int cycleCount = 0;

  ir_transmitter dut (
    .nec_clk  (nec_clk),
    .reset    (reset),
    .tx_word  (tx_word),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .ir_signal(ir_signal),
    .tx_done  (tx_done)
  );

  // Free-running protocol clock.
  always #HALF_PERIOD_NS nec_clk = ~nec_clk;

  // Absolute edge counter used to measure spacing between frames.
  always @(posedge nec_clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge nec_clk);
    @(negedge nec_clk);
  endtask

  // Idle line check over a number of cycles.
  task automatic idleCheck(input int cycles, input string tag);
    int errs;
    errs = 0;
    for (int i = 0; i < cycles; i++) begin
      stepCycle();
      if (ir_signal !== 1'b1 || tx_ready !== 1'b1 || tx_done !== 1'b0) errs++;
    end
    checkOutput(tag, errs, 0);
  endtask

  // Sends one word and follows it to the first idle cycle after the gap.
  // relDone is the cycle (counted from the accept edge) where tx_done was
  // seen, absDone the absolute edge count at that point.
  task automatic applyStimulus(input logic [31:0] word, input bit keepValid,
                               input bit poke, input string tag,
                               output int relDone, output int absDone);
    bit   expLine[$];
    int   highRuns[$];
    int   highRun, lineErr, readyErr, doneCount, bodyLen, lastIdx;
    logic [31:0] decoded;
    highRun = 0; lineErr = 0; readyErr = 0; doneCount = 0;
    relDone = -1; absDone = -1; decoded = '0;

    checkOutput({tag, " ready before send"}, 32'(tx_ready), 32'd1);
    tx_word  = word;
    tx_valid = 1'b1;

    repeat (T_LEAD_MARK) expLine.push_back(1'b0);
    repeat (T_LEAD_SPACE) expLine.push_back(1'b1);
    for (int b = 31; b >= 0; b--) begin
      repeat (T_BURST) expLine.push_back(1'b0);
      repeat (word[b] ? T_ONE_SPACE : T_ZERO_SPACE) expLine.push_back(1'b1);
    end
    repeat (T_BURST) expLine.push_back(1'b0);
    bodyLen = expLine.size();
    repeat (T_GAP) expLine.push_back(1'b1);
    expLine.push_back(1'b1);
    lastIdx = expLine.size() - 1;

    for (int n = 0; n <= lastIdx; n++) begin
      stepCycle();
      if (n == 0) tx_valid = keepValid;
      if (poke && (n == 300 || n == 700)) begin
        tx_word  = ~word;
        tx_valid = 1'b1;
      end
      if (poke && (n == 301 || n == 701)) tx_valid = 1'b0;
      if (ir_signal !== expLine[n]) lineErr++;
      if (tx_ready !== ((n == lastIdx) ? 1'b1 : 1'b0)) readyErr++;
      if (tx_done === 1'b1) begin
        doneCount++;
        relDone = n;
        absDone = cycleCount;
      end
      if (ir_signal === 1'b1) begin
        highRun++;
      end else if (highRun > 0) begin
        highRuns.push_back(highRun);
        highRun = 0;
      end
    end

    checkOutput({tag, " line waveform errors"}, lineErr, 0);
    checkOutput({tag, " ready timing errors"}, readyErr, 0);
    checkOutput({tag, " done pulse count"}, doneCount, 1);
    checkOutput({tag, " done cycle"}, relDone, bodyLen);
    checkOutput({tag, " decoded space count"}, highRuns.size(), 33);
    if (highRuns.size() == 33) begin
      for (int i = 1; i <= 32; i++) decoded = {decoded[30:0], (highRuns[i] > 20)};
    end
    checkOutput({tag, " loopback word"}, decoded, word);
  endtask

  initial begin
    int relA, absA, relB, absB, target, doneErr;
    logic [31:0] w;

    // Reset and idle.
    reset = 1'b1; tx_valid = 1'b0; tx_word = '0;
    #(3 * HALF_PERIOD_NS);
    @(negedge nec_clk);
    checkOutput("reset ir_signal", 32'(ir_signal), 32'd1);
    checkOutput("reset tx_ready", 32'(tx_ready), 32'd1);
    checkOutput("reset tx_done", 32'(tx_done), 32'd0);
    reset = 1'b0;
    idleCheck(20, "idle after reset");

    // Reference frame with 16 ones.
    applyStimulus(32'h20DF6A95, 1'b0, 1'b0, "word 20DF6A95", relA, absA);
    checkOutput("20DF6A95 done at 1210", relA, 32'd1210);

    // Back-to-back: valid held high, second accept on the first idle cycle,
    // so the high stretch between frames is the gap plus that idle cycle.
    applyStimulus(32'h00000000, 1'b1, 1'b0, "word 00000000", relA, absA);
    checkOutput("00000000 done at 890", relA, 32'd890);
    applyStimulus(32'hFFFFFFFF, 1'b0, 1'b0, "word FFFFFFFF", relB, absB);
    checkOutput("FFFFFFFF done at 1530", relB, 32'd1530);
    checkOutput("back-to-back spacing", absB - absA, T_GAP + 1 + 890 + 20 * 32);

    // Busy-time valid pulses and word changes must be ignored.
    applyStimulus(32'hA5C3_0F96, 1'b0, 1'b1, "busy poke", relA, absA);
    idleCheck(30, "no extra frame after poke");

    // Random words.
    for (int r = 0; r < 3; r++) begin
      w = $urandom();
      applyStimulus(w, 1'b0, 1'b0, $sformatf("random %0d", r), relA, absA);
      checkOutput($sformatf("random %0d done", r), relA, 890 + 20 * $countones(w));
    end

    // Reset in the mark of the 13th transmitted bit.
    w = $urandom();
    tx_word = w; tx_valid = 1'b1;
    stepCycle();
    tx_valid = 1'b0;
    target = T_LEAD_MARK + T_LEAD_SPACE + 5;
    for (int b = 31; b >= 20; b--) target += T_BURST + (w[b] ? T_ONE_SPACE : T_ZERO_SPACE);
    doneErr = 0;
    repeat (target) begin
      stepCycle();
      if (tx_done !== 1'b0) doneErr++;
    end
    checkOutput("in bit 12 mark", 32'(ir_signal), 32'd0);
    #1000 reset = 1'b1;
    #1;
    checkOutput("async reset line high", 32'(ir_signal), 32'd1);
    checkOutput("async reset ready", 32'(tx_ready), 32'd1);
    repeat (3) begin
      stepCycle();
      if (tx_done !== 1'b0) doneErr++;
    end
    reset = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      stepCycle();
      if (tx_done !== 1'b0) doneErr++;
    end
    checkOutput("no done around reset", doneErr, 0);
    checkOutput("ready after reset", 32'(tx_ready), 32'd1);
    applyStimulus(32'h20DF9A65, 1'b0, 1'b0, "word 20DF9A65", relA, absA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
